// File: rtl/kernel_tap_reader_pkg.sv
// Shared constants and types for the kernel tap read path.
// TAPS sizes both the kernel store and one tap sweep.
package cnn_pkg;
    localparam int KERNEL_M   = 3;
    localparam int KADDR_W    = 7;
    localparam int NWIN_W_DEF = 8;
    localparam int TAPS       = KERNEL_M * KERNEL_M;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/kernel_tap_reader_if.sv
// Valid/ready tap stream from the kernel reader to the convolution MAC.
interface kernel_tap_reader_if
    import cnn_pkg::*;
#(
    parameter int ADDR_W = KADDR_W
);
    logic              tap_valid;
    logic              tap_ready;
    logic              tap_bit;
    logic [ADDR_W-1:0] tap_idx;
    logic              tap_last;
    logic              win_last;

    modport master (
        output tap_valid, tap_bit, tap_idx, tap_last, win_last,
        input  tap_ready
    );

    modport slave (
        input  tap_valid, tap_bit, tap_idx, tap_last, win_last,
        output tap_ready
    );
endinterface

// File: rtl/kernel_tap_reader_tap_out_reg.sv
// One-entry valid/ready output register holding the current tap.
// Payload only changes on load, so a stalled tap stays stable.
module tap_out_reg
    import cnn_pkg::*;
#(
    parameter int ADDR_W = KADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              clear,
    input  logic              d_bit,
    input  logic [ADDR_W-1:0] d_idx,
    input  logic              d_last,
    input  logic              d_win_last,
    kernel_tap_reader_if.master tap
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tap.tap_valid <= 1'b0;
            tap.tap_bit   <= 1'b0;
            tap.tap_idx   <= '0;
            tap.tap_last  <= 1'b0;
            tap.win_last  <= 1'b0;
        end else if (clear) begin
            tap.tap_valid <= 1'b0;
            tap.tap_bit   <= 1'b0;
            tap.tap_idx   <= '0;
            tap.tap_last  <= 1'b0;
            tap.win_last  <= 1'b0;
        end else if (load) begin
            tap.tap_valid <= 1'b1;
            tap.tap_bit   <= d_bit;
            tap.tap_idx   <= d_idx;
            tap.tap_last  <= d_last;
            tap.win_last  <= d_win_last;
        end else if (tap.tap_valid && tap.tap_ready) begin
            tap.tap_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/kernel_tap_reader.sv
// Kernel store read sequencer: sweeps addresses 0..M*M-1 once per window and
// streams each sampled bit to the MAC through a one-entry output register.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing addresses / draining taps until final tap is consumed
//  DONE  | one-cycle done pulse, counters and tap register cleared
module kernel_tap_reader
    import cnn_pkg::*;
#(
    parameter int M      = KERNEL_M,
    parameter int ADDR_W = KADDR_W,
    parameter int NWIN_W = NWIN_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [NWIN_W-1:0] num_windows,
    output logic [ADDR_W-1:0] k_addr,
    input  logic              k_bit,
    kernel_tap_reader_if.master tap,
    output logic              busy,
    output logic              done
);

    localparam int                NTAPS     = M * M;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);

    state_t            state_q;
    state_t            state_d;
    logic              issuing_q;
    logic [NWIN_W-1:0] win_cnt_q;
    logic [NWIN_W-1:0] nwin_q;
    logic              load;
    logic              job_start;
    logic              clear;
    logic              consume;
    logic              addr_last;
    logic              win_final;

    assign consume   = tap.tap_valid && tap.tap_ready;
    assign addr_last = (k_addr == LAST_ADDR);
    // Full-width compare; win_cnt never exceeds nwin_q-1 while issuing.
    assign win_final = (win_cnt_q == (nwin_q - NWIN_W'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        job_start = 1'b0;
        clear     = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_windows != '0) begin
                        job_start = 1'b1;
                        state_d   = RUN;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            RUN: begin
                load = issuing_q && (!tap.tap_valid || tap.tap_ready);
                if (consume && tap.tap_last && tap.win_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                clear   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_addr    <= '0;
            win_cnt_q <= '0;
            nwin_q    <= '0;
            issuing_q <= 1'b0;
        end else if (job_start) begin
            k_addr    <= '0;
            win_cnt_q <= '0;
            nwin_q    <= num_windows;
            issuing_q <= 1'b1;
        end else if (load) begin
            if (addr_last) begin
                k_addr    <= '0;
                win_cnt_q <= win_cnt_q + NWIN_W'(1);
                if (win_final) issuing_q <= 1'b0;
            end else begin
                k_addr    <= k_addr + ADDR_W'(1);
            end
        end else if (clear) begin
            k_addr    <= '0;
            win_cnt_q <= '0;
            issuing_q <= 1'b0;
        end
    end

    tap_out_reg #(
        .ADDR_W (ADDR_W)
    ) u_tap_out_reg (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .clear      (clear),
        .d_bit      (k_bit),
        .d_idx      (k_addr),
        .d_last     (addr_last),
        .d_win_last (win_final),
        .tap        (tap)
    );

endmodule
